// File: rtl/resilient_controller_if.sv
// rtl/resilient_controller_if.sv - handshake, delay-element and error-rail bundle of one pipeline stage controller
interface resilient_controller_if;
    logic Lreq;
    logic Lack;
    logic LEreq;
    logic LEack;
    logic Rreq;
    logic REreq;
    logic REack;
    logic Rack;
    logic lclk;
    logic sample;
    logic Err0;
    logic Err1;

    // master = environment (stages, delay elements, detectors); slave = controller
    modport master (
        output Lreq, LEack, REreq, Rack, Err0, Err1,
        input  Lack, LEreq, Rreq, REack, lclk, sample
    );

    modport slave (
        input  Lreq, LEack, REreq, Rack, Err0, Err1,
        output Lack, LEreq, Rreq, REack, lclk, sample
    );
endinterface

// File: rtl/resilient_controller.sv
// rtl/resilient_controller.sv - error-resilient bundled-data stage controller: latch enable, error window, token forwarding
module resilient_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    resilient_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_EVAL,
        S_EXT,
        S_FWD
    } state_t;

    logic [5:0] w_in;
    logic [5:0] r_sync [SYNC_STAGES];
    logic [5:0] w_s;

    logic w_lreq;
    logic w_leack;
    logic w_rereq;
    logic w_rack;
    logic w_err0;
    logic w_err1;

    state_t r_state;
    state_t w_state_nxt;

    logic r_lack,   w_lack_nxt;
    logic r_lereq,  w_lereq_nxt;
    logic r_rreq,   w_rreq_nxt;
    logic r_reack,  w_reack_nxt;
    logic r_lclk,   w_lclk_nxt;
    logic r_sample, w_sample_nxt;

    assign w_in = {bus.Err1, bus.Err0, bus.Rack, bus.REreq, bus.LEack, bus.Lreq};

    // Every asynchronous input crosses the same-depth chain so relative ordering is preserved
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_lreq  = w_s[0];
    assign w_leack = w_s[1];
    assign w_rereq = w_s[2];
    assign w_rack  = w_s[3];
    assign w_err0  = w_s[4];
    assign w_err1  = w_s[5];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_lack   <= 1'b0;
            r_lereq  <= 1'b0;
            r_rreq   <= 1'b0;
            r_reack  <= 1'b0;
            r_lclk   <= 1'b0;
            r_sample <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lack   <= w_lack_nxt;
            r_lereq  <= w_lereq_nxt;
            r_rreq   <= w_rreq_nxt;
            r_reack  <= w_reack_nxt;
            r_lclk   <= w_lclk_nxt;
            r_sample <= w_sample_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lack_nxt   = r_lack;
        w_lereq_nxt  = r_lereq;
        w_rreq_nxt   = r_rreq;
        w_reack_nxt  = r_reack;
        w_lclk_nxt   = r_lclk;
        w_sample_nxt = r_sample;

        case (r_state)
            S_IDLE: begin
                // Start only once every return-to-zero of the previous token has been seen
                if (w_lreq && !r_lack && !w_rack && !r_reack && !w_leack &&
                    !w_rereq && !w_err0 && !w_err1) begin
                    w_lclk_nxt  = 1'b1;
                    w_lack_nxt  = 1'b1;
                    w_lereq_nxt = 1'b1;
                    w_state_nxt = S_OPEN;
                end
            end
            S_OPEN: begin
                if (w_leack) begin
                    w_lclk_nxt   = 1'b0;
                    w_sample_nxt = 1'b1;
                    w_state_nxt  = S_EVAL;
                end
            end
            S_EVAL: begin
                if (w_err1) begin
                    w_sample_nxt = 1'b0;
                    w_lereq_nxt  = 1'b0;
                    w_rreq_nxt   = 1'b1;
                    w_state_nxt  = S_EXT;
                end else if (w_err0) begin
                    w_sample_nxt = 1'b0;
                    w_lereq_nxt  = 1'b0;
                    w_reack_nxt  = 1'b1;
                    w_state_nxt  = S_FWD;
                end
            end
            S_EXT: begin
                if (w_rereq) begin
                    w_rreq_nxt  = 1'b0;
                    w_reack_nxt = 1'b1;
                    w_state_nxt = S_FWD;
                end
            end
            S_FWD: begin
                if (w_rack) begin
                    w_reack_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Left return-to-zero is decoupled from the token's progress through the stage
        if (r_lack && !w_lreq) begin
            w_lack_nxt = 1'b0;
        end
    end

    assign bus.Lack   = r_lack;
    assign bus.LEreq  = r_lereq;
    assign bus.Rreq   = r_rreq;
    assign bus.REack  = r_reack;
    assign bus.lclk   = r_lclk;
    assign bus.sample = r_sample;

endmodule

// File: tb/tb_resilient_controller.sv
// tb/tb_resilient_controller.sv - table-driven and randomized token checks for resilient_controller
module tb_resilient_controller;

    localparam int O_LCLK   = 0;
    localparam int O_SAMPLE = 1;
    localparam int O_LEREQ  = 2;
    localparam int O_RREQ   = 3;
    localparam int O_REACK  = 4;
    localparam int O_LACK   = 5;

    typedef struct {
        bit e0;
        bit e1;
        int le_dly;
        int err_dly;
        int re_dly;
        int rack_dly;
        bit exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [4:0] prev_snap = '0;
    logic [4:0] snap;
    logic [4:0] obs [$];
    int         overlap = 0;

    resilient_controller_if bus ();

    resilient_controller #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot {REack, Rreq, LEreq, sample, lclk}; record every change
    always @(negedge clk) begin
        if (!rst) begin
            prev_snap = '0;
        end else begin
            snap = {bus.REack, bus.Rreq, bus.LEreq, bus.sample, bus.lclk};
            if (snap != prev_snap) obs.push_back(snap);
            prev_snap = snap;
            if (bus.lclk && bus.sample) overlap++;
        end
    end

    function automatic logic get_out(input int idx);
        case (idx)
            O_LCLK:   return bus.lclk;
            O_SAMPLE: return bus.sample;
            O_LEREQ:  return bus.LEreq;
            O_RREQ:   return bus.Rreq;
            O_REACK:  return bus.REack;
            default:  return bus.Lack;
        endcase
    endfunction

    function automatic int outvec();
        return int'({bus.Lack, bus.REack, bus.Rreq, bus.LEreq, bus.sample, bus.lclk});
    endfunction

    function automatic logic [4:0] mk(input bit lclk_v, sample_v, lereq_v, rreq_v, reack_v);
        return {reack_v, rreq_v, lereq_v, sample_v, lclk_v};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_sig(input string nm, input int idx, input logic val, output int lat);
        bit done;
        done = 0;
        lat  = -1;
        for (int i = 1; i <= 400 && !done; i++) begin
            @(negedge clk);
            if (get_out(idx) === val) begin
                lat  = i;
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, output %0d never reached %0b", nm, idx, val);
        end
    endtask

    task automatic clear_inputs();
        bus.Lreq  = 1'b0;
        bus.LEack = 1'b0;
        bus.REreq = 1'b0;
        bus.Rack  = 1'b0;
        bus.Err0  = 1'b0;
        bus.Err1  = 1'b0;
    endtask

    task automatic run_token(input string nm, input bit e0, input bit e1,
                             input int le_dly, input int err_dly, input int re_dly,
                             input int rack_dly, input bit exp_err, input bit toggle);
        int lat;
        int bad;
        bit ok;
        logic [4:0] exp_q [$];

        // Reference: ordered output snapshots of a token, error rail taking priority
        exp_q.push_back(mk(1, 0, 1, 0, 0));
        exp_q.push_back(mk(0, 1, 1, 0, 0));
        if (exp_err) exp_q.push_back(mk(0, 0, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 0, 0, 0, 0));

        obs.delete();
        bus.Lreq = 1'b1;
        wait_sig({nm, " lereq_up"}, O_LEREQ, 1'b1, lat);
        check({nm, " lreq_to_lclk_lat"}, lat, 3);
        check({nm, " lclk_lack_up"}, {bus.lclk, bus.Lack}, 3);
        bus.Lreq = 1'b0;
        wait_sig({nm, " lack_down"}, O_LACK, 1'b0, lat);
        check({nm, " lack_rtz_lat"}, lat, 3);

        repeat (le_dly) @(negedge clk);
        bus.LEack = 1'b1;
        wait_sig({nm, " sample_up"}, O_SAMPLE, 1'b1, lat);
        check({nm, " leack_to_sample_lat"}, lat, 3);

        repeat (err_dly) @(negedge clk);
        bus.Err0 = e0;
        bus.Err1 = e1;
        if (exp_err) begin
            wait_sig({nm, " rreq_up"}, O_RREQ, 1'b1, lat);
            check({nm, " err_to_rreq_lat"}, lat, 3);
            repeat (re_dly) @(negedge clk);
            bus.REreq = 1'b1;
            wait_sig({nm, " reack_up"}, O_REACK, 1'b1, lat);
            check({nm, " rereq_to_reack_lat"}, lat, 3);
        end else begin
            wait_sig({nm, " reack_up"}, O_REACK, 1'b1, lat);
            check({nm, " err0_to_reack_lat"}, lat, 3);
        end
        bus.Err0  = 1'b0;
        bus.Err1  = 1'b0;
        bus.LEack = 1'b0;
        bus.REreq = 1'b0;

        bad = 0;
        for (int i = 0; i < rack_dly; i++) begin
            @(negedge clk);
            if (toggle) bus.Lreq = ((i / 6) % 2 == 1);
            if (bus.lclk !== 1'b0 || bus.REack !== 1'b1) bad++;
        end
        bus.Lreq = 1'b0;
        check({nm, " hold_while_rack_low"}, bad, 0);

        bus.Rack = 1'b1;
        wait_sig({nm, " reack_down"}, O_REACK, 1'b0, lat);
        check({nm, " rack_to_reack_down_lat"}, lat, 3);
        bus.Rack = 1'b0;
        repeat (6) @(negedge clk);

        ok = (obs.size() == exp_q.size());
        for (int i = 0; i < exp_q.size() && ok; i++) begin
            if (obs[i] !== exp_q[i]) ok = 0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s seq: got %0d output events expected %0d (first got %b, first expected %b)",
                     nm, obs.size(), exp_q.size(), (obs.size() > 0) ? obs[0] : 5'b0, exp_q[0]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        int   lat;
        int   r;
        bit   re0, re1;

        tbl[0] = '{e0: 1, e1: 0, le_dly: 20, err_dly: 2,  re_dly: 20, rack_dly: 3, exp_err: 0};
        tbl[1] = '{e0: 0, e1: 1, le_dly: 20, err_dly: 2,  re_dly: 20, rack_dly: 3, exp_err: 1};
        tbl[2] = '{e0: 1, e1: 1, le_dly: 5,  err_dly: 0,  re_dly: 5,  rack_dly: 0, exp_err: 1};
        tbl[3] = '{e0: 1, e1: 0, le_dly: 0,  err_dly: 0,  re_dly: 0,  rack_dly: 0, exp_err: 0};
        tbl[4] = '{e0: 0, e1: 1, le_dly: 0,  err_dly: 0,  re_dly: 0,  rack_dly: 0, exp_err: 1};
        tbl[5] = '{e0: 1, e1: 0, le_dly: 7,  err_dly: 11, re_dly: 3,  rack_dly: 9, exp_err: 0};

        clear_inputs();
        rst = 1'b0;
        bus.Lreq = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", outvec(), 0);
        rst = 1'b1;
        wait_sig("reset_release", O_LCLK, 1'b1, lat);
        check("reset_release_lat", lat, 3);

        // Abort the token while OPEN
        rst = 1'b0;
        #1;
        check("abort_open_outputs", outvec(), 0);
        clear_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_token($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].le_dly,
                      tbl[i].err_dly, tbl[i].re_dly, tbl[i].rack_dly, tbl[i].exp_err, 1'b0);
        end

        for (int i = 0; i < 16; i++) begin
            r   = $urandom_range(0, 2);
            re0 = (r != 1);
            re1 = (r != 0);
            run_token($sformatf("rnd%0d", i), re0, re1, $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                      re1, 1'b0);
        end

        run_token("slow_right", 1'b1, 1'b0, 20, 1, 0, 50, 1'b0, 1'b1);

        // Abort with sample high in EVAL, then a clean token
        bus.Lreq = 1'b1;
        wait_sig("abort_eval lereq_up", O_LEREQ, 1'b1, lat);
        bus.Lreq  = 1'b0;
        bus.LEack = 1'b1;
        wait_sig("abort_eval sample_up", O_SAMPLE, 1'b1, lat);
        rst = 1'b0;
        #1;
        check("abort_eval_outputs", outvec(), 0);
        clear_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        run_token("after_abort", 1'b1, 1'b0, 3, 1, 0, 2, 1'b0, 1'b0);

        check("lclk_sample_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
